// File: rtl/dma_pkt_loopback.sv
// rtl/dma_pkt_loopback.sv - stream loopback tester: ingress beats buffered in a RAM FIFO and replayed on egress
// Store-and-forward or cut-through release, packet accounting and clearable status counters.
module dma_pkt_loopback #(
  parameter logic [3:0] ID        = 4'h0,
  parameter int         DW        = 32,
  parameter int         FD        = 256,
  parameter             MODE      = "SF",
  parameter int         THRESH    = 16,
  parameter bit         DEST_PASS = 1'b0,
  localparam int        AW        = $clog2(FD),
  localparam int        CW        = AW + 1
) (
  input  logic            tester_clk,
  input  logic            tester_resetn,
  input  logic            tester_i_tvalid,
  output logic            tester_i_tready,
  input  logic [DW-1:0]   tester_i_tdata,
  input  logic [DW/8-1:0] tester_i_tkeep,
  input  logic [3:0]      tester_i_tdest,
  input  logic            tester_i_tlast,
  output logic            tester_o_tvalid,
  input  logic            tester_o_tready,
  output logic [DW-1:0]   tester_o_tdata,
  output logic [DW/8-1:0] tester_o_tkeep,
  output logic [3:0]      tester_o_tdest,
  output logic            tester_o_tlast,
  input  logic            clear_stats,
  output logic [15:0]     stat_pkt_in,
  output logic [15:0]     stat_pkt_out,
  output logic [CW-1:0]   stat_level,
  output logic            stat_oversize
);

  localparam int KW = DW / 8;
  localparam int EW = 1 + 4 + KW + DW;
  localparam bit IS_CT = (MODE == "CT");
  localparam logic [CW-1:0] FULL = CW'(FD);
  localparam logic [CW-1:0] THR  = CW'(THRESH);

  logic [EW-1:0] mem [FD];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] level_q, level_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          sending_q;
  logic          i_tready_q;
  logic          oversize_q;
  logic [15:0]   pkt_in_q, pkt_out_q;
  logic          wr, rd, wr_last, rd_last, o_valid;
  logic [EW-1:0] rd_word;

  assign rd_word = mem[rd_ptr_q];
  assign rd_last = rd_word[EW-1];
  assign wr      = tester_i_tvalid & i_tready_q;
  assign rd      = o_valid & tester_o_tready;
  assign wr_last = wr & tester_i_tlast;

  // Every term below only falls on a read, so valid never retracts before its handshake.
  assign o_valid = (level_q != '0) &&
                   ((pkt_cnt_q != '0) || sending_q || (level_q == FULL) ||
                    (IS_CT && (level_q >= THR)));

  always_comb begin
    level_d   = level_q + CW'(wr) - CW'(rd);
    pkt_cnt_d = pkt_cnt_q + CW'(wr_last) - CW'(rd & rd_last);
  end

  always_ff @(posedge tester_clk) begin
    if (wr) begin
      mem[wr_ptr_q] <= {tester_i_tlast, tester_i_tdest, tester_i_tkeep, tester_i_tdata};
    end
  end

  always_ff @(posedge tester_clk or negedge tester_resetn) begin
    if (!tester_resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_cnt_q  <= '0;
      sending_q  <= 1'b0;
      i_tready_q <= 1'b0;
      oversize_q <= 1'b0;
      pkt_in_q   <= '0;
      pkt_out_q  <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      pkt_cnt_q  <= pkt_cnt_d;
      i_tready_q <= (level_d < FULL);
      if (rd) sending_q <= ~rd_last;

      if (clear_stats) begin
        pkt_in_q   <= '0;
        pkt_out_q  <= '0;
        oversize_q <= 1'b0;
      end else begin
        if (wr_last)       pkt_in_q  <= pkt_in_q + 16'd1;
        if (rd && rd_last) pkt_out_q <= pkt_out_q + 16'd1;
        // A full buffer holding no complete packet can only be a packet longer than the FIFO.
        if (!IS_CT && (level_q == FULL) && (pkt_cnt_q == '0)) oversize_q <= 1'b1;
      end
    end
  end

  assign tester_i_tready = i_tready_q;
  assign tester_o_tvalid = o_valid;
  assign tester_o_tdata  = rd_word[DW-1:0];
  assign tester_o_tkeep  = rd_word[DW +: KW];
  assign tester_o_tdest  = DEST_PASS ? rd_word[DW+KW +: 4] : ID;
  assign tester_o_tlast  = rd_last;
  assign stat_pkt_in     = pkt_in_q;
  assign stat_pkt_out    = pkt_out_q;
  assign stat_level      = level_q;
  assign stat_oversize   = oversize_q;

endmodule

// File: tb/tb_dma_pkt_loopback.sv
// tb/tb_dma_pkt_loopback.sv - scoreboard bench for dma_pkt_loopback (SF instance a, CT dest-pass instance b)
module tb_dma_pkt_loopback;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rstn, a_ivalid, a_itready, a_ilast, a_ovalid, a_oready, a_olast, a_clr, a_ovs;
  logic [31:0] a_idata, a_odata;
  logic [3:0]  a_ikeep, a_okeep, a_idest, a_odest;
  logic [15:0] a_pin, a_pout;
  logic [8:0]  a_lvl;
  logic        b_rstn, b_ivalid, b_itready, b_ilast, b_ovalid, b_oready, b_olast, b_clr, b_ovs;
  logic [31:0] b_idata, b_odata;
  logic [3:0]  b_ikeep, b_okeep, b_idest, b_odest;
  logic [15:0] b_pin, b_pout;
  logic [8:0]  b_lvl;

  dma_pkt_loopback #(.ID(4'hA), .MODE("SF"), .DEST_PASS(1'b0)) u_a (
    .tester_clk(clk), .tester_resetn(a_rstn),
    .tester_i_tvalid(a_ivalid), .tester_i_tready(a_itready), .tester_i_tdata(a_idata),
    .tester_i_tkeep(a_ikeep), .tester_i_tdest(a_idest), .tester_i_tlast(a_ilast),
    .tester_o_tvalid(a_ovalid), .tester_o_tready(a_oready), .tester_o_tdata(a_odata),
    .tester_o_tkeep(a_okeep), .tester_o_tdest(a_odest), .tester_o_tlast(a_olast),
    .clear_stats(a_clr), .stat_pkt_in(a_pin), .stat_pkt_out(a_pout),
    .stat_level(a_lvl), .stat_oversize(a_ovs)
  );

  dma_pkt_loopback #(.ID(4'h7), .MODE("CT"), .THRESH(16), .DEST_PASS(1'b1)) u_b (
    .tester_clk(clk), .tester_resetn(b_rstn),
    .tester_i_tvalid(b_ivalid), .tester_i_tready(b_itready), .tester_i_tdata(b_idata),
    .tester_i_tkeep(b_ikeep), .tester_i_tdest(b_idest), .tester_i_tlast(b_ilast),
    .tester_o_tvalid(b_ovalid), .tester_o_tready(b_oready), .tester_o_tdata(b_odata),
    .tester_o_tkeep(b_okeep), .tester_o_tdest(b_odest), .tester_o_tlast(b_olast),
    .clear_stats(b_clr), .stat_pkt_in(b_pin), .stat_pkt_out(b_pout),
    .stat_level(b_lvl), .stat_oversize(b_ovs)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [40:0] q_a[$];
  logic [40:0] q_b[$];
  logic [40:0] e_a, e_b;
  logic a_seen_v = 1'b0;
  logic a_done, b_done;
  logic b_rand = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Beat word layout: {last, dest, keep, data}
  always @(negedge clk) begin
    if (a_ovalid) a_seen_v = 1'b1;
    if (a_ovalid && a_oready) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL a_unexpected_beat: actual=%0h required=none", {a_olast, a_odest, a_okeep, a_odata});
      end else begin
        e_a = q_a.pop_front();
        chk("a_beat", {a_olast, a_odest, a_okeep, a_odata}, e_a);
      end
    end
  end

  always @(negedge clk) begin
    if (b_ovalid && b_oready) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_unexpected_beat: actual=%0h required=none", {b_olast, b_odest, b_okeep, b_odata});
      end else begin
        e_b = q_b.pop_front();
        chk("b_beat", {b_olast, b_odest, b_okeep, b_odata}, e_b);
      end
    end
  end

  always @(posedge clk) begin
    if (b_rand) begin
      #1;
      b_oready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input bit ib, input int n, input int base, input logic [3:0] dest,
                      input logic [3:0] keep, input bit eop);
    int t;
    logic acc;
    logic [40:0] w;
    for (int i = 0; i < n; i++) begin
      w = {(eop && (i == n - 1)), dest, keep, 32'(base + i)};
      if (ib) begin {b_ilast, b_idest, b_ikeep, b_idata} = w; b_ivalid = 1'b1; end
      else    begin {a_ilast, a_idest, a_ikeep, a_idata} = w; a_ivalid = 1'b1; end
      acc = 1'b0;
      t = 0;
      while (!acc && t < 4000) begin
        @(negedge clk);
        acc = ib ? b_itready : a_itready;
        t++;
        if (acc) begin
          if (ib) q_b.push_back(w);
          else    q_a.push_back({w[40], 4'hA, w[35:0]});
        end
        @(posedge clk); #1;
      end
      if (!acc) begin
        n_cmp++; n_fail++;
        $display("FAIL %s_send_timeout: beat %0d accepted=0 required=1", ib ? "b" : "a", i);
        break;
      end
    end
    if (ib) begin b_ivalid = 1'b0; b_ilast = 1'b0; end
    else    begin a_ivalid = 1'b0; a_ilast = 1'b0; end
  endtask

  task automatic wait_drain(input bit ib, input int lim);
    int t;
    t = 0;
    while (t < lim && (((ib ? q_b.size() : q_a.size()) != 0) || ((ib ? b_lvl : a_lvl) != 0))) begin
      @(posedge clk); #1;
      t++;
    end
    chk(ib ? "b_drain_queue" : "a_drain_queue", ib ? q_b.size() : q_a.size(), 0);
    chk(ib ? "b_drain_level" : "a_drain_level", ib ? b_lvl : a_lvl, 0);
  endtask

  task automatic wait_flag(input string nm, input bit ib, input int lim);
    int t;
    t = 0;
    while (t < lim && !(ib ? b_done : a_done)) begin
      @(posedge clk); #1;
      t++;
    end
    chk(nm, ib ? b_done : a_done, 1);
  endtask

  task automatic clear_a();
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    chk("a_clr_pkt_in", a_pin, 0);
    chk("a_clr_pkt_out", a_pout, 0);
    chk("a_clr_oversize", a_ovs, 0);
  endtask

  initial begin
    int t;
    a_rstn = 0; a_ivalid = 0; a_oready = 0; a_clr = 0; a_idata = 0; a_ikeep = 0; a_idest = 0; a_ilast = 0;
    b_rstn = 0; b_ivalid = 0; b_oready = 0; b_clr = 0; b_idata = 0; b_ikeep = 0; b_idest = 0; b_ilast = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_itready", a_itready, 0);
    chk("rst_a_ovalid", a_ovalid, 0);
    chk("rst_a_level", a_lvl, 0);
    chk("rst_a_stats", {a_pin, a_pout, a_ovs}, 0);
    chk("rst_b_itready", b_itready, 0);
    a_rstn = 1; b_rstn = 1;
    @(posedge clk); #1;
    chk("post_rst_a_itready", a_itready, 1);
    chk("post_rst_b_itready", b_itready, 1);

    // SF: nothing leaves before tlast is stored, then 8 back-to-back beats
    a_oready = 1; a_seen_v = 0;
    send(0, 8, 0, 4'h3, 4'hF, 1);
    chk("sf_no_early_valid", a_seen_v, 0);
    chk("sf_valid_after_tlast", a_ovalid, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("sf_consecutive_drain", q_a.size(), 0);
    chk("sf_level", a_lvl, 0);
    chk("sf_pkt_in", a_pin, 1);
    chk("sf_pkt_out", a_pout, 1);

    // Full FIFO under backpressure, then drain 300 beats
    clear_a();
    a_oready = 0; a_done = 0;
    fork
      begin
        send(0, 100, 1000, 4'h1, 4'hF, 1);
        send(0, 100, 2000, 4'h1, 4'hF, 1);
        send(0, 100, 3000, 4'h1, 4'hF, 1);
        a_done = 1;
      end
    join_none
    t = 0;
    while (a_lvl != 256 && t < 1000) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
    chk("full_level", a_lvl, 256);
    chk("full_itready", a_itready, 0);
    chk("full_ovalid", a_ovalid, 1);
    chk("full_pkt_in", a_pin, 2);
    a_oready = 1;
    wait_flag("full_send_done", 0, 2000);
    wait_drain(0, 500);
    chk("full_pkt_out", a_pout, 3);

    // Oversize packet in SF
    clear_a();
    a_done = 0;
    fork
      begin
        send(0, 300, 5000, 4'h2, 4'h7, 1);
        a_done = 1;
      end
    join_none
    t = 0;
    while (!a_ovalid && t < 1000) begin @(posedge clk); #1; t++; end
    chk("ovs_start_level", a_lvl, 256);
    wait_flag("ovs_send_done", 0, 2000);
    wait_drain(0, 500);
    chk("ovs_flag", a_ovs, 1);
    chk("ovs_pkt_out", a_pout, 1);
    clear_a();

    // Asynchronous reset with buffered data and valid asserted
    a_oready = 0;
    send(0, 4, 7000, 4'h4, 4'hF, 1);
    send(0, 3, 7100, 4'h4, 4'hF, 0);
    chk("mid_ovalid_before", a_ovalid, 1);
    #3;
    a_rstn = 0;
    #1;
    chk("mid_rst_itready", a_itready, 0);
    chk("mid_rst_ovalid", a_ovalid, 0);
    chk("mid_rst_level", a_lvl, 0);
    chk("mid_rst_pkt_in", a_pin, 0);
    q_a.delete();
    @(posedge clk); #1;
    a_rstn = 1;
    @(posedge clk); #1;
    a_oready = 1;
    send(0, 4, 8000, 4'h4, 4'hF, 1);
    wait_drain(0, 100);
    chk("mid_post_pkt_out", a_pout, 1);

    // CT: egress begins at threshold
    b_oready = 1; b_done = 0;
    fork
      begin
        send(1, 40, 0, 4'h2, 4'hF, 1);
        b_done = 1;
      end
    join_none
    t = 0;
    while (!b_ovalid && t < 200) begin @(posedge clk); #1; t++; end
    chk("ct_start_level", b_lvl, 16);
    wait_flag("ct_send_done", 1, 200);
    wait_drain(1, 200);
    chk("ct_pkt_out", b_pout, 1);

    // Dest pass-through with random backpressure, incl. single-beat packet
    b_rand = 1;
    send(1, 5, 100, 4'h3, 4'hF, 1);
    send(1, 1, 200, 4'h9, 4'h1, 1);
    send(1, 7, 300, 4'h5, 4'hC, 1);
    b_rand = 0;
    @(posedge clk); #2;
    b_oready = 1;
    wait_drain(1, 200);
    chk("dp_pkt_in", b_pin, 4);
    chk("dp_pkt_out", b_pout, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
